// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned MEM_AW_DEF = 14;
  localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way winner select: lock filter, then round-robin or
// fixed-priority tie break.
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  input  logic       lock_i,
  output logic       valid_o,
  output logic       winner_o
);

  logic [1:0] eff_req;

  // Mask the non-owner while locked, then resolve ties.
  always_comb begin
    eff_req = req_i;
    if (lock_i) begin
      eff_req = (last_owner_i == PORT1) ? (req_i & 2'b10) : (req_i & 2'b01);
    end
    valid_o  = |eff_req;
    winner_o = PORT0;
    if (eff_req == 2'b11) begin
      winner_o = FIXED_PRIO ? PORT0 : ~last_owner_i;
    end else if (eff_req[1]) begin
      winner_o = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port word RAM: one outstanding
// transaction, IDLE -> ACCESS -> RESP, optional ownership lock.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned MEM_AW = MEM_AW_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Write0,
  input  logic              Write1,
  input  logic              Lock0,
  input  logic              Lock1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              RValid0,
  output logic              RValid1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic [MEM_AW-1:0] Mem_Address,
  output logic              Mem_WriteEnable,
  output logic [DATA_W-1:0] Mem_WriteData,
  input  logic [DATA_W-1:0] Mem_ReadData
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              write_q, write_d;
  logic              lock_q, lock_d;
  logic              last_q, last_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [MEM_AW-1:0] maddr_q, maddr_d;
  logic              mwe_q, mwe_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;

  logic              pick_valid;
  logic              pick_winner;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_write;
  logic              sel_lock;
  logic [DATA_W-1:0] sel_wdata;

  // Byte-lane and above-RAM address bits are dropped; RAM accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Addr0[1:0], Addr1[1:0],
                              Addr0[ADDR_W-1:MEM_AW+2], Addr1[ADDR_W-1:MEM_AW+2]};

  rr_pick2 #(
    .FIXED_PRIO(FixedPrio)
  ) u_pick (
    .req_i       ({Req1, Req0}),
    .last_owner_i(last_q),
    .lock_i      (lock_q),
    .valid_o     (pick_valid),
    .winner_o    (pick_winner)
  );

  // Mux the winning requester's transaction fields.
  always_comb begin
    sel_addr  = (pick_winner == PORT1) ? Addr1  : Addr0;
    sel_write = (pick_winner == PORT1) ? Write1 : Write0;
    sel_lock  = (pick_winner == PORT1) ? Lock1  : Lock0;
    sel_wdata = (pick_winner == PORT1) ? WData1 : WData0;
  end

  // Next-state and registered-output logic; every output is a flop so the
  // RAM pins are driven only from this block.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    write_d  = write_q;
    lock_d   = lock_q;
    last_d   = last_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    maddr_d  = maddr_q;
    mwe_d    = 1'b0;
    mwdata_d = mwdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d             = pick_winner;
          write_d             = sel_write;
          lock_d              = sel_lock;
          maddr_d             = sel_addr[MEM_AW+1:2];
          mwdata_d            = sel_wdata;
          mwe_d               = sel_write;
          gnt_d[pick_winner]  = 1'b1;
          state_d             = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        rvalid_d[owner_q] = 1'b1;
        if (!write_q) begin
          if (owner_q == PORT1) begin
            rdata1_d = Mem_ReadData;
          end else begin
            rdata0_d = Mem_ReadData;
          end
        end
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      owner_q  <= PORT0;
      write_q  <= 1'b0;
      lock_q   <= 1'b0;
      last_q   <= PORT1;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      maddr_q  <= '0;
      mwe_q    <= 1'b0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      write_q  <= write_d;
      lock_q   <= lock_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      maddr_q  <= maddr_d;
      mwe_q    <= mwe_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign Gnt0            = gnt_q[0];
  assign Gnt1            = gnt_q[1];
  assign RValid0         = rvalid_q[0];
  assign RValid1         = rvalid_q[1];
  assign RData0          = rdata0_q;
  assign RData1          = rdata1_q;
  assign Mem_Address     = maddr_q;
  assign Mem_WriteEnable = mwe_q;
  assign Mem_WriteData   = mwdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port word RAM between two requesters: port 0 (Processor memory interface) and port 1 (loader/DMA/debug master).
- Sits between the masters and the RAM; it alone drives the RAM Address/MemWrite/WriteData pins.
- Round-robin arbitration, one outstanding transaction, optional lock to hold ownership across a burst.

Parameters:
- ADDR_W, 32, requester byte-address width
- MEM_AW, 14, RAM word-address width; RAM address = byte address [MEM_AW+1:2]
- DATA_W, 32, data width

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Req0/Req1  in  1  request; held until GntN sampled high
- Write0/Write1  in  1  1 = write, 0 = read
- Lock0/Lock1  in  1  keep ownership after this transaction
- Addr0/Addr1  in  ADDR_W  byte address
- WData0/WData1  in  DATA_W  write data
- Gnt0/Gnt1  out  1  one-cycle pulse: request accepted and registered
- RValid0/RValid1  out  1  one-cycle pulse: RData valid / write completed
- RData0/RData1  out  DATA_W  read data, held until next RValid on that port
- Mem_Address  out  MEM_AW  RAM word address
- Mem_WriteEnable  out  1  RAM write strobe
- Mem_WriteData  out  DATA_W  RAM write data
- Mem_ReadData  in  DATA_W  RAM read data, valid the cycle after address presented

Behaviour:
- Reset: state IDLE, all Gnt/RValid/Mem_WriteEnable 0, Mem_Address 0, Mem_WriteData 0, RData 0, last-owner = 1 (port 0 wins first tie), lock cleared. Reset mid-transaction aborts; no RValid issued.
- States: IDLE, ACCESS, RESP.
- IDLE: if any Req, pick winner, pulse GntN, register Write/Addr/WData/Lock, go ACCESS. Tie: port that is not last-owner wins. Single requester always wins.
- ACCESS (1 cycle): drive Mem_Address = Addr[MEM_AW+1:2], Mem_WriteData; Mem_WriteEnable = Write. Write -> RValidN pulse next cycle via RESP; read -> RESP.
- RESP (1 cycle): read: capture Mem_ReadData into RDataN, pulse RValidN. Write: pulse RValidN only. Update last-owner. Go IDLE.
- Lock: if registered LockN = 1, owner stays locked; in IDLE only owner's Req is considered; other port waits indefinitely. Lock released by a transaction with LockN = 0.
- Latency: request to Gnt 1 cycle; Gnt to RValid 2 cycles; throughput 1 transaction / 3 cycles.
- Mem_WriteEnable asserted only during ACCESS; outside ACCESS Mem_Address holds last value.
- Addr[1:0] ignored; upper bits above MEM_AW+1 ignored (wrap-around in RAM).
- Req deasserted before Gnt: request withdrawn, no effect.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins ties (processor priority); last-owner unused; lock still honoured.
- Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ACCESS, RESP), port index constants, MEM_AW/DATA_W defaults.
- Sub-module rr_pick2: combinational 2-way winner select from Req, last-owner, lock and priority mode.

Test Plan:
- Port 0 write 0xDEADBEEF @0x40 then read @0x40 -> Mem_Address 0x10, Mem_WriteEnable one cycle, RValid0 with RData0 = 0xDEADBEEF, 2 cycles after Gnt0.
- Both Req every cycle after reset -> grants alternate 0,1,0,1; with MEM_ARB_FIXED_PRIO_EN Gnt0 only.
- Port 1 Lock1 = 1 for 3 reads @0x0,0x4,0x8, port 0 requesting -> three Gnt1 before any Gnt0; Gnt0 after Lock1 = 0 transaction.
- Reset asserted during ACCESS of a read -> no RValid, state IDLE, outputs at reset values next cycle.
- Addr0 = 0x0001_0004 read -> Mem_Address = 0x0001 (upper bits dropped).
- Req1 pulsed one cycle while port 0 owns bus, then dropped -> no Gnt1, no RAM access for port 1.
